// File: rtl/ads_spi_sequencer_if.sv
// Host-side bus of the ADS1256 SPI sequencer: transaction handshake plus the serial pins.
// The sequencer uses the slave modport; the environment (host logic / bench) uses master.
interface ads_spi_sequencer_if #(
  parameter int MAX_TX_BYTES = 3,
  parameter int MAX_RX_BYTES = 3
);
  logic                                  start_i;
  logic [$clog2(MAX_TX_BYTES+1)-1:0]     tx_count_i;
  logic [$clog2(MAX_RX_BYTES+1)-1:0]     rx_count_i;
  logic                                  wait_drdy_i;
  logic [8*MAX_TX_BYTES-1:0]             tx_data_i;
  logic                                  busy_o;
  logic                                  done_o;
  logic                                  timeout_o;
  logic [8*MAX_RX_BYTES-1:0]             rx_data_o;
  logic                                  DRDY_L_i;
  logic                                  MISO_i;
  logic                                  MOSI_o;
  logic                                  SCLK_o;
  logic                                  CS_L_o;

  modport slave (
    input  start_i, tx_count_i, rx_count_i, wait_drdy_i, tx_data_i, DRDY_L_i, MISO_i,
    output busy_o, done_o, timeout_o, rx_data_o, MOSI_o, SCLK_o, CS_L_o
  );

  modport master (
    output start_i, tx_count_i, rx_count_i, wait_drdy_i, tx_data_i, DRDY_L_i, MISO_i,
    input  busy_o, done_o, timeout_o, rx_data_o, MOSI_o, SCLK_o, CS_L_o
  );
endinterface

// File: rtl/ads_spi_sequencer.sv
// SPI mode-1 master and single-frame transaction sequencer for the ADS1256:
// optional DRDY wait, N command bytes, optional t6 gap, M read bytes under one CS_L.
module ads_spi_sequencer #(
  parameter int MAX_TX_BYTES = 3,
  parameter int MAX_RX_BYTES = 3,
  parameter int CLK_DIV      = 4,
  parameter int T6_CYCLES    = 50,
  parameter int DRDY_TIMEOUT = 100000
) (
  input logic              clock_i,
  input logic              reset_L_i,
  ads_spi_sequencer_if.slave bus
);
  localparam int TXW       = $clog2(MAX_TX_BYTES + 1);
  localparam int RXW       = $clog2(MAX_RX_BYTES + 1);
  localparam int BITW      = ((TXW > RXW) ? TXW : RXW) + 3;
  localparam int TXB       = 8 * MAX_TX_BYTES;
  localparam int RXB       = 8 * MAX_RX_BYTES;
  localparam int CNT_MAX_A = (DRDY_TIMEOUT > T6_CYCLES) ? DRDY_TIMEOUT : T6_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > 2 * CLK_DIV) ? CNT_MAX_A : 2 * CLK_DIV;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]  CD_CNT   = CW'(CLK_DIV);
  localparam logic [CW-1:0]  CD_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  CD2_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0]  T6_LAST  = CW'(T6_CYCLES - 1);
  localparam logic [CW-1:0]  TO_LAST  = CW'(DRDY_TIMEOUT - 1);
  localparam logic [TXW-1:0] TX_MAX   = TXW'(MAX_TX_BYTES);
  localparam logic [RXW-1:0] RX_MAX   = RXW'(MAX_RX_BYTES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_TX    = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_RX    = 3'd5;
  localparam logic [2:0] S_HOLD  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITW-1:0] bits_q, bits_d;
  logic [TXW-1:0]  tx_n_q, tx_n_d;
  logic [RXW-1:0]  rx_n_q, rx_n_d;
  logic [TXB-1:0]  tx_sh_q, tx_sh_d;
  logic [RXB-1:0]  rx_sh_q, rx_sh_d;
  logic [RXB-1:0]  rx_data_q, rx_data_d;
  logic [1:0]      drdy_sync_q, drdy_sync_d;
  logic            timeout_q, timeout_d;
  logic            cs_l_q, cs_l_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [TXB-1:0]  tx_swapped;
  logic [TXW-1:0]  tx_clamped;
  logic [RXW-1:0]  rx_clamped;
  logic [BITW-1:0] rx_bits;

  // Byte 0 is placed at the top so TX simply shifts the whole buffer left, MSB first.
  for (genvar gi = 0; gi < MAX_TX_BYTES; gi++) begin : g_swap
    assign tx_swapped[8*(MAX_TX_BYTES-1-gi) +: 8] = bus.tx_data_i[8*gi +: 8];
  end

  assign tx_clamped = (bus.tx_count_i > TX_MAX) ? TX_MAX : bus.tx_count_i;
  assign rx_clamped = (bus.rx_count_i > RX_MAX) ? RX_MAX : bus.rx_count_i;
  assign rx_bits    = BITW'({rx_n_q, 3'b000});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bits_d      = bits_q;
    tx_n_d      = tx_n_q;
    rx_n_d      = rx_n_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    timeout_d   = timeout_q;
    drdy_sync_d = {drdy_sync_q[0], bus.DRDY_L_i};

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start_i) begin
          tx_n_d    = tx_clamped;
          rx_n_d    = rx_clamped;
          tx_sh_d   = tx_swapped;
          rx_sh_d   = '0;
          timeout_d = 1'b0;
          if (tx_clamped == '0 && rx_clamped == '0) begin
            state_d = S_DONE;
          end else if (bus.wait_drdy_i) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_WAIT: begin
        if (!drdy_sync_q[1]) begin
          state_d = S_SETUP;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_q == CD_LAST) begin
          cnt_d = '0;
          if (tx_n_q != '0) begin
            state_d = S_TX;
            bits_d  = BITW'({tx_n_q, 3'b000});
          end else begin
            state_d = S_RX;
            bits_d  = rx_bits;
          end
        end
      end
      S_TX: begin
        if (cnt_q == CD2_LAST) begin
          cnt_d   = '0;
          tx_sh_d = tx_sh_q << 1;
          if (bits_q == BITW'(1)) begin
            if (rx_n_q == '0) begin
              state_d = S_HOLD;
            end else if (T6_CYCLES > 0) begin
              state_d = S_GAP;
            end else begin
              state_d = S_RX;
              bits_d  = rx_bits;
            end
          end else begin
            bits_d = bits_q - BITW'(1);
          end
        end
      end
      S_GAP: begin
        if (cnt_q == T6_LAST) begin
          cnt_d   = '0;
          state_d = S_RX;
          bits_d  = rx_bits;
        end
      end
      S_RX: begin
        // Sample in the last high-phase cycle so the capture lands on the SCLK falling edge.
        if (cnt_q == CD_LAST) begin
          rx_sh_d = {rx_sh_q[RXB-2:0], bus.MISO_i};
        end
        if (cnt_q == CD2_LAST) begin
          cnt_d = '0;
          if (bits_q == BITW'(1)) begin
            state_d = S_HOLD;
          end else begin
            bits_d = bits_q - BITW'(1);
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == CD_LAST) begin
          state_d   = S_DONE;
          rx_data_d = rx_sh_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pin values are derived from the next state so every output leaves a flop, glitch-free.
    cs_l_d = !(state_d inside {S_SETUP, S_TX, S_GAP, S_RX, S_HOLD});
    sclk_d = (state_d == S_TX || state_d == S_RX) && (cnt_d < CD_CNT);
    mosi_d = (state_d == S_TX) && tx_sh_d[TXB-1];
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_L_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bits_q      <= '0;
      tx_n_q      <= '0;
      rx_n_q      <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      drdy_sync_q <= 2'b11;
      timeout_q   <= 1'b0;
      cs_l_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      tx_n_q      <= tx_n_d;
      rx_n_q      <= rx_n_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      drdy_sync_q <= drdy_sync_d;
      timeout_q   <= timeout_d;
      cs_l_q      <= cs_l_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.timeout_o = timeout_q;
  assign bus.rx_data_o = rx_data_q;
  assign bus.MOSI_o    = mosi_q;
  assign bus.SCLK_o    = sclk_q;
  assign bus.CS_L_o    = cs_l_q;
endmodule

// File: tb/tb_ads_spi_sequencer.sv
// Directed and randomized transactions against a cycle-count / byte-stream model of the
// ADS1256 sequencer, with a simple MISO responder that shifts a word out on SCLK rises.
module tb_ads_spi_sequencer;
  localparam int CD = 2;
  localparam int T6 = 8;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [23:0] prev_rx = '0;

  always #5 clk = ~clk;

  ads_spi_sequencer_if #(.MAX_TX_BYTES(3), .MAX_RX_BYTES(3)) bus ();

  ads_spi_sequencer #(
    .MAX_TX_BYTES(3), .MAX_RX_BYTES(3), .CLK_DIV(CD), .T6_CYCLES(T6), .DRDY_TIMEOUT(TO)
  ) dut (
    .clock_i  (clk),
    .reset_L_i(rst_l),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input string name, input int txn, input int rxn, input bit wt,
                         input logic [23:0] txd, input logic [23:0] miso_w, input int drdy_at,
                         input int extra_start_at, input bit start_on_done, input int reset_at);
    int done_cnt = 0, done_off = -1, cs_low = 0, cs_first = -1, rises = 0, idle_bad = 0;
    int g, d, cs_start, exp_done, exp_cs_low, j;
    bit timed_out, empty;
    logic busy0 = 1'b0, to_at_done = 1'b0, prev_sclk = 1'b0;
    logic [23:0] mosi_bits = '0, rx_at_done = '0, exp_mosi = '0, exp_rx, tmp;
    logic [31:0] mask;

    empty     = (txn + rxn == 0);
    timed_out = wt && !empty && (drdy_at < 0);
    g         = (txn > 0 && rxn > 0) ? T6 : 0;
    d         = CD * (2 + 16 * (txn + rxn)) + g;
    cs_start  = wt ? drdy_at + 3 : 0;
    exp_done  = empty ? 0 : (timed_out ? TO : cs_start + d);
    exp_cs_low = (empty || timed_out) ? 0 : d;
    for (int i = 0; i < txn && !timed_out; i++) exp_mosi = (exp_mosi << 8) | ((txd >> (8 * i)) & 24'hFF);
    mask = (32'h1 << (8 * rxn)) - 32'h1;
    if (empty || timed_out) exp_rx = prev_rx;
    else exp_rx = miso_w & mask[23:0];

    @(negedge clk);
    bus.tx_count_i  = 2'(txn);
    bus.rx_count_i  = 2'(rxn);
    bus.wait_drdy_i = wt;
    bus.tx_data_i   = txd;
    bus.DRDY_L_i    = 1'b1;
    bus.MISO_i      = 1'b0;
    bus.start_i     = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;

    for (int off = 0; off < 500; off++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      if (off == 0) busy0 = bus.busy_o;
      if (off == drdy_at) bus.DRDY_L_i = 1'b0;
      if (off == extra_start_at) bus.start_i = 1'b1;
      if (bus.CS_L_o) begin
        if (bus.SCLK_o || bus.MOSI_o) idle_bad++;
      end else begin
        cs_low++;
        if (cs_first < 0) cs_first = off;
        bus.DRDY_L_i = 1'b1;
      end
      if (bus.SCLK_o && !prev_sclk) begin
        if (rises < 8 * txn) begin
          mosi_bits = {mosi_bits[22:0], bus.MOSI_o};
        end else if (rises - 8 * txn < 8 * rxn) begin
          j = 8 * rxn - 1 - (rises - 8 * txn);
          tmp = miso_w >> j;
          bus.MISO_i = tmp[0];
        end
        rises++;
      end
      prev_sclk = bus.SCLK_o;
      if (bus.done_o) begin
        done_cnt++;
        if (done_off < 0) begin
          done_off   = off;
          to_at_done = bus.timeout_o;
          rx_at_done = bus.rx_data_o;
        end
        if (start_on_done) bus.start_i = 1'b1;
      end
      if (reset_at >= 0 && off == reset_at) rst_l = 1'b0;
      if (reset_at >= 0 && off == reset_at + 1) begin
        rst_l = 1'b1;
        chk({name, ".rst_cs_l"}, {31'd0, bus.CS_L_o}, 32'd1);
        chk({name, ".rst_sclk"}, {31'd0, bus.SCLK_o}, 32'd0);
        chk({name, ".rst_busy"}, {31'd0, bus.busy_o}, 32'd0);
        chk({name, ".rst_rx"}, {8'd0, bus.rx_data_o}, 32'd0);
        chk({name, ".rst_done"}, {31'd0, bus.done_o}, 32'd0);
      end
      if (reset_at < 0 && done_off >= 0 && off >= done_off + 8) break;
      if (reset_at >= 0 && off >= reset_at + 10) break;
    end
    bus.start_i  = 1'b0;
    bus.DRDY_L_i = 1'b1;
    bus.MISO_i   = 1'b0;

    if (reset_at >= 0) begin
      chk({name, ".rst_no_done"}, done_cnt, 0);
      prev_rx = '0;
    end else begin
      chk({name, ".busy_start"}, {31'd0, busy0}, 32'd1);
      chk({name, ".done_cnt"}, done_cnt, 1);
      chk({name, ".done_off"}, done_off, exp_done);
      chk({name, ".cs_low_cycles"}, cs_low, exp_cs_low);
      if (exp_cs_low > 0) chk({name, ".cs_first"}, cs_first, cs_start);
      chk({name, ".sclk_rises"}, rises, (empty || timed_out) ? 0 : 8 * (txn + rxn));
      chk({name, ".mosi"}, {8'd0, mosi_bits}, {8'd0, exp_mosi});
      chk({name, ".rx_data"}, {8'd0, rx_at_done}, {8'd0, exp_rx});
      chk({name, ".timeout"}, {31'd0, to_at_done}, {31'd0, timed_out});
      chk({name, ".idle_pins"}, idle_bad, 0);
      chk({name, ".busy_end"}, {31'd0, bus.busy_o}, 32'd0);
      prev_rx = exp_rx;
    end
    $display("[TB] txn %s tx=%0d rx=%0d wait=%0d done_off=%0d rx_data=%0h timeout=%0b",
             name, txn, rxn, wt, done_off, rx_at_done, to_at_done);
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.tx_count_i  = '0;
    bus.rx_count_i  = '0;
    bus.wait_drdy_i = 1'b0;
    bus.tx_data_i   = '0;
    bus.DRDY_L_i    = 1'b1;
    bus.MISO_i      = 1'b0;
    rst_l           = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.cs_l", {31'd0, bus.CS_L_o}, 32'd1);
    chk("reset.sclk", {31'd0, bus.SCLK_o}, 32'd0);
    chk("reset.mosi", {31'd0, bus.MOSI_o}, 32'd0);
    chk("reset.busy", {31'd0, bus.busy_o}, 32'd0);
    chk("reset.done", {31'd0, bus.done_o}, 32'd0);
    chk("reset.timeout", {31'd0, bus.timeout_o}, 32'd0);
    chk("reset.rx", {8'd0, bus.rx_data_o}, 32'd0);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);

    run_txn("rdata",   1, 3, 1'b0, 24'h000001, 24'hABCDEF, -1, -1, 1'b0, -1);
    run_txn("reset_rx", 1, 3, 1'b0, 24'h000001, 24'h5A5A5A, -1, -1, 1'b0, 80);
    run_txn("after_rst", 1, 3, 1'b0, 24'h000001, 24'h123456, -1, -1, 1'b0, -1);
    run_txn("timeout", 2, 1, 1'b1, 24'h00AA55, 24'h0000FF, -1, -1, 1'b0, -1);
    run_txn("wreg",    3, 0, 1'b0, 24'h010050, 24'h000000, -1, -1, 1'b0, -1);
    run_txn("drdy",    1, 3, 1'b1, 24'h000001, 24'h8C3E71, 19, -1, 1'b0, -1);
    run_txn("ign_start", 2, 1, 1'b0, 24'h00C3A7, 24'h0000B4, -1, 10, 1'b1, -1);
    run_txn("empty",   0, 0, 1'b0, 24'h000000, 24'h000000, -1, -1, 1'b1, -1);

    for (int n = 0; n < 10; n++) begin
      int rtx, rrx, rdrdy;
      bit rwt;
      rtx   = $urandom_range(0, 3);
      rrx   = $urandom_range(0, 3);
      rwt   = 1'($urandom_range(0, 1));
      rdrdy = rwt ? $urandom_range(0, 40) : -1;
      run_txn($sformatf("rand%0d", n), rtx, rrx, rwt, 24'($urandom), 24'($urandom),
              rdrdy, -1, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
